// File: rtl/adc_spi_responder.sv
// ---------------------------------------------------------------------------
// adc_spi_responder
//
// SPI slave transmitter that stands in for an ADCS7476-style ADC. A locally
// supplied sample is framed as LEAD_ZEROS zero bits followed by DATA_WIDTH
// data bits, MSB first, and driven onto the master's din line. The master
// samples on sck rising edges; this block changes dout on sck falling edges.
//
// Ports:
//   clk          system clock
//   n_rst        asynchronous active-low reset
//   sck          SPI clock from the master (async to clk, idles high)
//   cs           active-low chip select from the master (async to clk)
//   sample_data  next sample value
//   sample_valid one-cycle strobe that captures sample_data
//   dout         serial data to the master
//   dout_oe      high while a frame is being driven
//   frame_done   one-cycle pulse when a full frame completes
//   frame_abort  one-cycle pulse when cs rises mid-frame
//   stale        the last frame re-sent a sample that had already been sent
//
// FRAME_BITS must equal DATA_WIDTH + LEAD_ZEROS, and SYNC_STAGES must be at
// least 2.
// ---------------------------------------------------------------------------
module adc_spi_responder #(
  parameter int DATA_WIDTH  = 12,
  parameter int LEAD_ZEROS  = 4,
  parameter int FRAME_BITS  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  sck,
  input  logic                  cs,
  input  logic [DATA_WIDTH-1:0] sample_data,
  input  logic                  sample_valid,
  output logic                  dout,
  output logic                  dout_oe,
  output logic                  frame_done,
  output logic                  frame_abort,
  output logic                  stale
);

  localparam int CNT_W = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    WAIT_CS
  } state_t;

  // Synchroniser chains and edge-detector history. Everything resets to the
  // idle-high level so no spurious edge appears at reset release.
  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic                   sck_prev;
  logic                   cs_prev;

  // prime fills with ones once the synchroniser has flushed its reset value;
  // only then does cs_sync reflect the real pad level.
  logic [SYNC_STAGES-1:0] prime;
  logic                   cs_armed;

  logic sck_s;
  logic cs_s;
  logic sck_fall;
  logic cs_fall;
  logic cs_rise;

  state_t                  state_q, state_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]   sample_q;
  logic                    fresh_q;
  logic                    dout_q, dout_d;
  logic                    oe_q, oe_d;
  logic                    done_q, done_d;
  logic                    abort_q, abort_d;
  logic                    stale_q, stale_d;
  logic                    load_frame;
  logic [DATA_WIDTH-1:0]   load_sample;
  logic [FRAME_BITS-1:0]   frame_word;

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sck_fall = sck_prev & ~sck_s;
  assign cs_fall  = cs_prev & ~cs_s;
  assign cs_rise  = ~cs_prev & cs_s;

  // A sample strobe in the same cycle as the frame load is bypassed straight
  // into the frame so the newest value goes out.
  assign load_sample = sample_valid ? sample_data : sample_q;
  assign frame_word  = {{LEAD_ZEROS{1'b0}}, load_sample};

  // Input synchronisers, edge history and the cs arming logic. A cs that is
  // already low when reset releases must not start a frame, so cs has to be
  // seen high (after the chain has flushed) before any falling edge counts.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sck_sync <= '1;
      cs_sync  <= '1;
      sck_prev <= 1'b1;
      cs_prev  <= 1'b1;
      prime    <= '0;
      cs_armed <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck};
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], cs};
      sck_prev <= sck_s;
      cs_prev  <= cs_s;
      prime    <= {prime[SYNC_STAGES-2:0], 1'b1};
      if (prime[SYNC_STAGES-1] && cs_s) begin
        cs_armed <= 1'b1;
      end
    end
  end

  // Sample register and the fresh flag. Loading a frame consumes the sample,
  // which takes priority over a coincident strobe (that strobe was bypassed).
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sample_q <= '0;
      fresh_q  <= 1'b0;
    end else begin
      if (sample_valid) begin
        sample_q <= sample_data;
      end
      if (load_frame) begin
        fresh_q <= 1'b0;
      end else if (sample_valid) begin
        fresh_q <= 1'b1;
      end
    end
  end

  // State and output registers; all outputs come straight from flops.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      dout_q    <= 1'b0;
      oe_q      <= 1'b0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
      stale_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      dout_q    <= dout_d;
      oe_q      <= oe_d;
      done_q    <= done_d;
      abort_q   <= abort_d;
      stale_q   <= stale_d;
    end
  end

  // Next-state and next-output logic. In SHIFT a cs rise is checked before a
  // sck fall so a simultaneous pair aborts without shifting.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    dout_d     = dout_q;
    oe_d       = oe_q;
    done_d     = 1'b0;
    abort_d    = 1'b0;
    stale_d    = stale_q;
    load_frame = 1'b0;

    case (state_q)
      IDLE: begin
        dout_d = 1'b0;
        oe_d   = 1'b0;
        if (cs_fall && cs_armed) begin
          load_frame = 1'b1;
          state_d    = SHIFT;
          shift_d    = frame_word;
          dout_d     = frame_word[FRAME_BITS-1];
          oe_d       = 1'b1;
          bit_cnt_d  = '0;
          stale_d    = sample_valid ? 1'b0 : ~fresh_q;
        end
      end

      SHIFT: begin
        if (cs_rise) begin
          state_d = IDLE;
          dout_d  = 1'b0;
          oe_d    = 1'b0;
          abort_d = 1'b1;
        end else if (sck_fall) begin
          if (bit_cnt_q == LAST_BIT) begin
            state_d = WAIT_CS;
            dout_d  = 1'b0;
            oe_d    = 1'b0;
            done_d  = 1'b1;
          end else begin
            shift_d   = {shift_q[FRAME_BITS-2:0], 1'b0};
            dout_d    = shift_q[FRAME_BITS-2];
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end

      WAIT_CS: begin
        dout_d = 1'b0;
        oe_d   = 1'b0;
        if (cs_rise) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        dout_d  = 1'b0;
        oe_d    = 1'b0;
      end
    endcase
  end

  assign dout        = dout_q;
  assign dout_oe     = oe_q;
  assign frame_done  = done_q;
  assign frame_abort = abort_q;
  assign stale       = stale_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// ---------------------------------------------------------------------------
// tb_adc_spi_responder
//
// Directed bench for adc_spi_responder. A table of frame records (sample,
// whether to strobe it, abort point, expected 16-bit word, expected stale)
// is played through a small SPI master model, followed by hand-written
// sequences for sample bypass, simultaneous cs-rise/sck-fall and reset in
// the middle of a frame. Each sck phase lasts four clk cycles.
// ---------------------------------------------------------------------------
module tb_adc_spi_responder;

  typedef struct {
    logic [11:0] sample;
    logic        load;
    int          abort_at;
    logic [15:0] exp_word;
    logic        exp_stale;
  } vec_t;

  logic        clk;
  logic        n_rst;
  logic        sck;
  logic        cs;
  logic [11:0] sample_data;
  logic        sample_valid;
  logic        dout;
  logic        dout_oe;
  logic        frame_done;
  logic        frame_abort;
  logic        stale;

  int          checks;
  int          failures;
  int          done_cnt;
  int          abort_cnt;
  logic [15:0] rx_word;
  vec_t        vecs[5];

  adc_spi_responder #(
    .DATA_WIDTH (12),
    .LEAD_ZEROS (4),
    .FRAME_BITS (16),
    .SYNC_STAGES(2)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .sck         (sck),
    .cs          (cs),
    .sample_data (sample_data),
    .sample_valid(sample_valid),
    .dout        (dout),
    .dout_oe     (dout_oe),
    .frame_done  (frame_done),
    .frame_abort (frame_abort),
    .stale       (stale)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count pulses seen on the two strobe outputs, sampled mid-cycle.
  always @(negedge clk) begin
    if (frame_done)  done_cnt  = done_cnt + 1;
    if (frame_abort) abort_cnt = abort_cnt + 1;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_output(input string name, input logic [15:0] act,
                              input logic [15:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drop cs and capture the first bit the slave presents.
  task automatic start_frame();
    rx_word = '0;
    cs = 1'b0;
    wait_cycles(4);
    rx_word[15] = dout;
  endtask

  // One sck fall then rise per bit; the master samples after the rise.
  task automatic shift_bits(input int first, input int last);
    for (int k = first; k <= last; k++) begin
      sck = 1'b0;
      wait_cycles(4);
      sck = 1'b1;
      wait_cycles(4);
      rx_word[15-k] = dout;
    end
  endtask

  // Final sck fall: frame_done must rise exactly three cycles after the pad
  // edge, last one cycle, and a later cs rise must produce no pulse.
  task automatic finish_frame();
    int a0;
    a0 = abort_cnt;
    sck = 1'b0;
    wait_cycles(2);
    check_output("done_early", 16'(frame_done), 16'd0);
    wait_cycles(1);
    check_output("done_pulse", 16'(frame_done), 16'd1);
    check_output("done_oe", 16'(dout_oe), 16'd0);
    check_output("done_dout", 16'(dout), 16'd0);
    wait_cycles(1);
    check_output("done_width", 16'(frame_done), 16'd0);
    sck = 1'b1;
    wait_cycles(4);
    cs = 1'b1;
    wait_cycles(5);
    check_output("waitcs_no_abort", 16'(abort_cnt), 16'(a0));
  endtask

  task automatic apply_stimulus(input vec_t v);
    int          d0;
    int          a0;
    logic [15:0] mask;
    if (v.load) begin
      sample_data  = v.sample;
      sample_valid = 1'b1;
      wait_cycles(1);
      sample_valid = 1'b0;
      wait_cycles(1);
    end
    d0 = done_cnt;
    a0 = abort_cnt;
    check_output("idle_oe", 16'(dout_oe), 16'd0);
    start_frame();
    check_output("start_oe", 16'(dout_oe), 16'd1);
    check_output("start_stale", 16'(stale), 16'(v.exp_stale));
    if (v.abort_at == 0) begin
      shift_bits(1, 15);
      finish_frame();
      check_output("frame_word", rx_word, v.exp_word);
      check_output("frame_done_count", 16'(done_cnt), 16'(d0 + 1));
      check_output("frame_abort_count", 16'(abort_cnt), 16'(a0));
    end else begin
      shift_bits(1, v.abort_at - 1);
      cs = 1'b1;
      wait_cycles(5);
      mask = '1;
      mask = mask << (16 - v.abort_at);
      check_output("abort_prefix", rx_word & mask, v.exp_word & mask);
      check_output("abort_count", 16'(abort_cnt), 16'(a0 + 1));
      check_output("abort_no_done", 16'(done_cnt), 16'(d0));
      check_output("abort_oe", 16'(dout_oe), 16'd0);
      check_output("abort_dout", 16'(dout), 16'd0);
    end
  endtask

  initial begin
    int a0;
    int d0;

    checks       = 0;
    failures     = 0;
    done_cnt     = 0;
    abort_cnt    = 0;
    rx_word      = '0;
    n_rst        = 1'b0;
    sck          = 1'b1;
    cs           = 1'b1;
    sample_data  = '0;
    sample_valid = 1'b0;

    vecs[0] = '{sample: 12'hA5C, load: 1'b1, abort_at: 0, exp_word: 16'h0A5C, exp_stale: 1'b0};
    vecs[1] = '{sample: 12'h000, load: 1'b0, abort_at: 0, exp_word: 16'h0A5C, exp_stale: 1'b1};
    vecs[2] = '{sample: 12'hFFF, load: 1'b1, abort_at: 8, exp_word: 16'h0FFF, exp_stale: 1'b0};
    vecs[3] = '{sample: 12'h000, load: 1'b0, abort_at: 0, exp_word: 16'h0FFF, exp_stale: 1'b1};
    vecs[4] = '{sample: 12'h456, load: 1'b1, abort_at: 0, exp_word: 16'h0456, exp_stale: 1'b0};

    // Reset state
    wait_cycles(3);
    check_output("rst_dout", 16'(dout), 16'd0);
    check_output("rst_oe", 16'(dout_oe), 16'd0);
    check_output("rst_done", 16'(frame_done), 16'd0);
    check_output("rst_abort", 16'(frame_abort), 16'd0);
    check_output("rst_stale", 16'(stale), 16'd0);
    n_rst = 1'b1;
    wait_cycles(5);

    for (int i = 0; i < 5; i++) begin
      $display("[TB] vector %0d", i);
      apply_stimulus(vecs[i]);
    end

    // Bypass: register holds an already-sent 0x456; 0x123 arrives in the
    // very cycle the cs fall is detected and must go out, not flagged stale.
    $display("[TB] bypass");
    d0 = done_cnt;
    rx_word = '0;
    cs = 1'b0;
    wait_cycles(2);
    sample_data  = 12'h123;
    sample_valid = 1'b1;
    wait_cycles(1);
    sample_valid = 1'b0;
    check_output("bypass_oe", 16'(dout_oe), 16'd1);
    check_output("bypass_stale", 16'(stale), 16'd0);
    rx_word[15] = dout;
    shift_bits(1, 15);
    finish_frame();
    check_output("bypass_word", rx_word, 16'h0123);
    check_output("bypass_done_count", 16'(done_cnt), 16'(d0 + 1));

    // Simultaneous cs rise and 10th sck fall: abort wins, nothing shifts.
    // The bypassed strobe left fresh clear, so this frame is stale.
    $display("[TB] simultaneous edges");
    a0 = abort_cnt;
    d0 = done_cnt;
    start_frame();
    check_output("simul_stale", 16'(stale), 16'd1);
    shift_bits(1, 9);
    sck = 1'b0;
    cs  = 1'b1;
    wait_cycles(2);
    check_output("simul_abort_early", 16'(frame_abort), 16'd0);
    wait_cycles(1);
    check_output("simul_abort_pulse", 16'(frame_abort), 16'd1);
    check_output("simul_dout", 16'(dout), 16'd0);
    check_output("simul_oe", 16'(dout_oe), 16'd0);
    sck = 1'b1;
    wait_cycles(4);
    check_output("simul_prefix", rx_word & 16'hFFC0, 16'h0123 & 16'hFFC0);
    check_output("simul_abort_count", 16'(abort_cnt), 16'(a0 + 1));
    check_output("simul_no_done", 16'(done_cnt), 16'(d0));

    // Reset in the middle of a frame, with cs held low through release.
    $display("[TB] reset mid-frame");
    start_frame();
    shift_bits(1, 9);
    check_output("pre_rst_oe", 16'(dout_oe), 16'd1);
    a0 = abort_cnt;
    d0 = done_cnt;
    n_rst = 1'b0;
    #1;
    check_output("midrst_oe", 16'(dout_oe), 16'd0);
    check_output("midrst_dout", 16'(dout), 16'd0);
    check_output("midrst_stale", 16'(stale), 16'd0);
    wait_cycles(2);
    n_rst = 1'b1;
    wait_cycles(10);
    check_output("cs_low_release_oe", 16'(dout_oe), 16'd0);
    check_output("midrst_no_pulse", 16'(abort_cnt + done_cnt), 16'(a0 + d0));
    cs = 1'b1;
    wait_cycles(6);
    start_frame();
    check_output("post_rst_oe", 16'(dout_oe), 16'd1);
    check_output("post_rst_dout", 16'(dout), 16'd0);
    check_output("post_rst_stale", 16'(stale), 16'd1);
    shift_bits(1, 15);
    finish_frame();
    check_output("post_rst_word", rx_word, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
